serial_carry_adder: RTL and testbench



---
 rtl/serial_carry_adder_pkg.sv | 22 ++
 rtl/serial_carry_adder_carry.sv | 26 ++
 rtl/serial_carry_adder.sv | 159 +++++++++++++++
 tb/tb_serial_carry_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_carry_adder_pkg.sv
// Shared types and helpers for serial_carry_adder: FSM state encoding and
// digit-counter width calculation.
package serial_carry_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Counter must hold 0..N-1 where N = width/digit, and is never narrower than one bit.
   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = width / digit;
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_carry_adder_carry.sv
// carry_digit: combinational DIGIT-bit ripple of full-adder sum/carry cells.
module carry_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] c_s;

   // Ripple the carry through DIGIT full-adder cells, LSB first.
   always_comb begin
      c_s    = '0;
      s      = '0;
      c_s[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]     = x[i] ^ y[i] ^ c_s[i];
         c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
      end
      co = c_s[DIGIT];
   end

endmodule

// File: rtl/serial_carry_adder.sv
// serial_carry_adder: LSB-first multi-cycle adder, DIGIT bits per clock, valid/ready on both sides.
// Optional subtract mode (adds the `sub` port) is enabled by defining SERIAL_CARRY_ADDER_SUB_EN.
module serial_carry_adder
   import serial_carry_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_CARRY_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(WIDTH, DIGIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_carry_adder: WIDTH must be >= 1 and a multiple of DIGIT");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             sub_q, sub_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             sub_in_s;
   logic [DIGIT-1:0] dsum_s;
   logic             dco_s;

`ifdef SERIAL_CARRY_ADDER_SUB_EN
   assign sub_in_s = sub;
`else
   assign sub_in_s = 1'b0;
`endif

   carry_digit #(.DIGIT(DIGIT)) u_digit (
      .x  (a_q[DIGIT-1:0]),
      .y  (b_q[DIGIT-1:0]),
      .ci (carry_q),
      .s  (dsum_s),
      .co (dco_s)
   );

   // Next-state and datapath: subtract is folded in at load time (invert b, invert carry-in).
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      sub_d       = sub_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = sub_in_s ? ~b : b;
               carry_d    = cin ^ sub_in_s;
               sub_d      = sub_in_s;
               cnt_d      = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d    = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dco_s;
            sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               cout_d      = dco_s ^ sub_q;
            end else begin
               state_d     = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d     = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         sub_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         sub_q       <= sub_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Scoreboard bench for serial_carry_adder (WIDTH=8, DIGIT=1 main instance, DIGIT=4 side instance).
// Define SERIAL_CARRY_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_carry_adder;

   localparam int W = 8;
`ifdef SERIAL_CARRY_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy, sub_tb;
   logic [W-1:0] a, b, sum;
   logic         in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
   logic [W-1:0] a4, b4, sum4;

   int n_checks = 0;
   int n_errors = 0;
   int n_issued = 0;
   int n_seen   = 0;
   bit rand_ready = 1'b0;
   logic [W:0] exp_q[$];

   serial_carry_adder #(.WIDTH(W), .DIGIT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SERIAL_CARRY_ADDER_SUB_EN
      .sub(sub_tb),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
   );

   serial_carry_adder #(.WIDTH(W), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_CARRY_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain (W+1)-bit arithmetic; in subtract mode bit W is the borrow.
   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
      logic [W:0] r;
      if (s) r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
      else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      return r;
   endfunction

   // Offer an operand pair; push the expectation once the DUT shows it will accept.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
      int k;
      a = x; b = y; cin = ci; sub_tb = s; in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 200);
      if (!in_ready) begin
         chk("accept_timeout", {63'd0, in_ready}, 64'd1);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(ref_op(x, y, ci, s));
         n_issued++;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_tb = 1'($urandom);
      end
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever a result handshake is about to happen.
   always @(negedge clk) begin
      logic [W:0] e;
      if (rst_n) begin
         chk("in_ready_vs_busy", {63'd0, in_ready}, {63'd0, !busy});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               n_seen++;
               chk("sum", {56'd0, sum}, {56'd0, e[W-1:0]});
               chk("cout", {63'd0, cout}, {63'd0, e[W]});
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int k;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub_tb = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_sum", {56'd0, sum}, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
      rst_n = 1'b1;

      // 0xFF + 0x01: full carry ripple, latency N=8.
      issue(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_valid(k);
      chk("lat_ff01", k, 64'd8);
      chk("sum_ff01", {56'd0, sum}, 64'h00);
      chk("cout_ff01", {63'd0, cout}, 64'd1);
      release_result();

      // 0x5A + 0x25 + 1 with the consumer stalling for 5 cycles.
      issue(8'h5A, 8'h25, 1'b1, 1'b0);
      wait_valid(k);
      chk("lat_5a25", k, 64'd8);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_sum", {56'd0, sum}, 64'h80);
         chk("stall_cout", {63'd0, cout}, 64'd0);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      release_result();
      chk("post_done_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_done_out_valid", {63'd0, out_valid}, 64'd0);

      // DIGIT=4 instance: 0x9C + 0x7B, latency 2.
      a4 = 8'h9C; b4 = 8'h7B; cin4 = 1'b0; in_valid4 = 1'b1;
      @(negedge clk);
      chk("d4_in_ready", {63'd0, in_ready4}, 64'd1);
      @(posedge clk);
      #1;
      in_valid4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
      k = 0;
      while (!out_valid4 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("d4_latency", k, 64'd2);
      chk("d4_sum", {56'd0, sum4}, 64'h17);
      chk("d4_cout", {63'd0, cout4}, 64'd1);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      chk("d4_back_idle", {63'd0, in_ready4}, 64'd1);

      // Reset in RUN cycle 3 discards the operation in flight.
      issue(8'h30, 8'h41, 1'b1, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      n_issued -= exp_q.size();
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_sum", {56'd0, sum}, 64'd0);
      chk("midrst_cout", {63'd0, cout}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      issue(8'h03, 8'h04, 1'b0, 1'b0);
      wait_valid(k);
      chk("after_rst_sum", {56'd0, sum}, 64'h07);
      release_result();

      if (HAS_SUB) begin
         issue(8'h10, 8'h01, 1'b0, 1'b1);
         wait_valid(k);
         chk("sub_10_01_sum", {56'd0, sum}, 64'h0F);
         chk("sub_10_01_cout", {63'd0, cout}, 64'd0);
         release_result();
         issue(8'h01, 8'h02, 1'b0, 1'b1);
         wait_valid(k);
         chk("sub_01_02_sum", {56'd0, sum}, 64'hFF);
         chk("sub_01_02_cout", {63'd0, cout}, 64'd1);
         release_result();
      end

      // Random operands with random producer gaps and consumer stalls.
      rand_ready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         issue(W'($urandom), W'($urandom), 1'($urandom), HAS_SUB ? 1'($urandom) : 1'b0);
      end
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      rand_ready = 1'b0;
      out_ready = 1'b0;
      chk("drained", exp_q.size(), 64'd0);
      chk("results_vs_issued", n_seen, n_issued);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
